// File: rtl/defs_insn.sv
// Shared instruction definitions for the Venus execute stage: widths,
// opcode encodings, condition selectors and flag bit positions.
package defs_insn;

    localparam int LEN_OPECODE = 6;
    localparam int LEN_IMMF    = 1;
    localparam int LEN_REG     = 32;
    localparam int LEN_CC      = 4;
    localparam int LEN_IMM_EX  = 32;
    localparam int LEN_FLAGS   = 4;

    localparam logic [LEN_OPECODE-1:0] OPECODE_ADD   = 6'h00;
    localparam logic [LEN_OPECODE-1:0] OPECODE_SUB   = 6'h01;
    localparam logic [LEN_OPECODE-1:0] OPECODE_AND   = 6'h02;
    localparam logic [LEN_OPECODE-1:0] OPECODE_OR    = 6'h03;
    localparam logic [LEN_OPECODE-1:0] OPECODE_XOR   = 6'h04;
    localparam logic [LEN_OPECODE-1:0] OPECODE_NOT   = 6'h05;
    localparam logic [LEN_OPECODE-1:0] OPECODE_SHL   = 6'h06;
    localparam logic [LEN_OPECODE-1:0] OPECODE_SHR   = 6'h07;
    localparam logic [LEN_OPECODE-1:0] OPECODE_SAR   = 6'h08;
    localparam logic [LEN_OPECODE-1:0] OPECODE_MOV   = 6'h09;
    localparam logic [LEN_OPECODE-1:0] OPECODE_MOVCC = 6'h0A;
    localparam logic [LEN_OPECODE-1:0] OPECODE_CMP   = 6'h0B;

    localparam logic [LEN_CC-1:0] CC_AL  = 4'd0;
    localparam logic [LEN_CC-1:0] CC_EQ  = 4'd1;
    localparam logic [LEN_CC-1:0] CC_NE  = 4'd2;
    localparam logic [LEN_CC-1:0] CC_LT  = 4'd3;
    localparam logic [LEN_CC-1:0] CC_GE  = 4'd4;
    localparam logic [LEN_CC-1:0] CC_LTU = 4'd5;
    localparam logic [LEN_CC-1:0] CC_GEU = 4'd6;

    // flags word is {Z,N,C,V}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic cond_true(input logic [LEN_CC-1:0] cc,
                                       input logic [LEN_FLAGS-1:0] flags);
        logic res;
        res = 1'b0;
        case (cc)
            CC_AL:   res = 1'b1;
            CC_EQ:   res = flags[FLAG_Z];
            CC_NE:   res = ~flags[FLAG_Z];
            CC_LT:   res = flags[FLAG_N] ^ flags[FLAG_V];
            CC_GE:   res = ~(flags[FLAG_N] ^ flags[FLAG_V]);
            CC_LTU:  res = flags[FLAG_C];
            CC_GEU:  res = ~flags[FLAG_C];
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/execute_alu.sv
// Combinational ALU for the execute stage: result and next flags from
// opcode, operands, condition selector and the current flags.
module execute_alu
    import defs_insn::*;
(
    input  logic [LEN_OPECODE-1:0] opecode,
    input  logic [LEN_REG-1:0]     a,
    input  logic [LEN_REG-1:0]     b,
    input  logic [LEN_CC-1:0]      cc,
    input  logic [LEN_FLAGS-1:0]   flags,
    output logic [LEN_REG-1:0]     result,
    output logic [LEN_FLAGS-1:0]   flags_nxt
);

    logic [4:0]         shamt;
    logic [LEN_REG:0]   sum_w;
    logic [LEN_REG:0]   diff_w;
    logic [LEN_REG:0]   shl_w;
    logic [LEN_REG:0]   shr_w;
    logic [LEN_REG:0]   sar_w;
    logic               add_v;
    logic               sub_v;

    // Extra bit catches the last bit shifted out; it stays 0 for amount 0.
    assign shamt  = b[4:0];
    assign sum_w  = {1'b0, a} + {1'b0, b};
    assign diff_w = {1'b0, a} - {1'b0, b};
    assign shl_w  = {1'b0, a} << shamt;
    assign shr_w  = {a, 1'b0} >> shamt;
    assign sar_w  = $signed({a, 1'b0}) >>> shamt;
    assign add_v  = (a[LEN_REG-1] == b[LEN_REG-1]) && (sum_w[LEN_REG-1] != a[LEN_REG-1]);
    assign sub_v  = (a[LEN_REG-1] != b[LEN_REG-1]) && (diff_w[LEN_REG-1] != a[LEN_REG-1]);

    always_comb begin
        logic [LEN_REG-1:0] flag_src;
        logic               c_nxt;
        logic               v_nxt;
        logic               upd;
        result   = '0;
        flag_src = '0;
        c_nxt    = 1'b0;
        v_nxt    = 1'b0;
        upd      = 1'b1;
        case (opecode)
            OPECODE_ADD: begin
                result = sum_w[LEN_REG-1:0];
                c_nxt  = sum_w[LEN_REG];
                v_nxt  = add_v;
            end
            OPECODE_SUB: begin
                result = diff_w[LEN_REG-1:0];
                c_nxt  = diff_w[LEN_REG];
                v_nxt  = sub_v;
            end
            OPECODE_AND: result = a & b;
            OPECODE_OR:  result = a | b;
            OPECODE_XOR: result = a ^ b;
            OPECODE_NOT: result = ~b;
            OPECODE_SHL: begin
                result = shl_w[LEN_REG-1:0];
                c_nxt  = shl_w[LEN_REG];
            end
            OPECODE_SHR: begin
                result = shr_w[LEN_REG:1];
                c_nxt  = shr_w[0];
            end
            OPECODE_SAR: begin
                result = sar_w[LEN_REG:1];
                c_nxt  = sar_w[0];
            end
            OPECODE_MOV: result = b;
            OPECODE_MOVCC: begin
                result = cond_true(cc, flags) ? b : a;
                upd    = 1'b0;
            end
            OPECODE_CMP: begin
                result = a;
                c_nxt  = diff_w[LEN_REG];
                v_nxt  = sub_v;
            end
            default: begin
                result = '0;
                upd    = 1'b0;
            end
        endcase

        flag_src = (opecode == OPECODE_CMP) ? diff_w[LEN_REG-1:0] : result;
        if (upd) begin
            flags_nxt = {(flag_src == '0), flag_src[LEN_REG-1], c_nxt, v_nxt};
        end else begin
            flags_nxt = flags;
        end
    end

endmodule

// File: rtl/execute.sv
// Venus execute stage: operand-B select, ALU, and the registered result
// and architectural flags with one-cycle latency.
module execute
    import defs_insn::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LEN_OPECODE-1:0] opecode,
    input  logic [LEN_IMMF-1:0]    immf,
    input  logic [LEN_REG-1:0]     data_rd,
    input  logic [LEN_REG-1:0]     data_rs,
    input  logic [LEN_CC-1:0]      cc,
    input  logic [LEN_IMM_EX-1:0]  imm_ex,
    output logic [LEN_REG-1:0]     data_o,
    output logic [LEN_FLAGS-1:0]   flags_o
);

    logic [LEN_REG-1:0]   opnd_b;
    logic [LEN_REG-1:0]   alu_result;
    logic [LEN_FLAGS-1:0] alu_flags;

    assign opnd_b = immf[0] ? imm_ex : data_rs;

    execute_alu u_alu (
        .opecode   (opecode),
        .a         (data_rd),
        .b         (opnd_b),
        .cc        (cc),
        .flags     (flags_o),
        .result    (alu_result),
        .flags_nxt (alu_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o  <= '0;
            flags_o <= '0;
        end else begin
            data_o  <= alu_result;
            flags_o <= alu_flags;
        end
    end

endmodule

// File: tb/tb_execute.sv
// Directed bench for the execute stage with hand-computed expectations.
module tb_execute;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opecode;
    logic [0:0]  immf;
    logic [31:0] data_rd;
    logic [31:0] data_rs;
    logic [3:0]  cc;
    logic [31:0] imm_ex;
    logic [31:0] data_o;
    logic [3:0]  flags_o;

    int n_cmp;
    int n_bad;

    execute dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .opecode (opecode),
        .immf    (immf),
        .data_rd (data_rd),
        .data_rs (data_rs),
        .cc      (cc),
        .imm_ex  (imm_ex),
        .data_o  (data_o),
        .flags_o (flags_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic do_op(input logic [5:0] op, input logic im, input logic [31:0] rd,
                         input logic [31:0] rs, input logic [31:0] imm, input logic [3:0] c);
        @(negedge clk);
        opecode = op;
        immf    = im;
        data_rd = rd;
        data_rs = rs;
        imm_ex  = imm;
        cc      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic op_chk(input string tag, input logic [5:0] op, input logic im,
                          input logic [31:0] rd, input logic [31:0] rs, input logic [31:0] imm,
                          input logic [3:0] c, input logic [31:0] exp_d, input logic [3:0] exp_f);
        do_op(op, im, rd, rs, imm, c);
        chk({tag, ".data"}, data_o, exp_d);
        chk({tag, ".flags"}, {28'h0, flags_o}, {28'h0, exp_f});
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        opecode = 6'h00;
        immf    = 1'b0;
        data_rd = 32'h0;
        data_rs = 32'h0;
        cc      = 4'h0;
        imm_ex  = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset.data", data_o, 32'h0);
        chk("reset.flags", {28'h0, flags_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // flags order {Z,N,C,V}
        op_chk("add",      6'h00, 1'b0, 32'h1234_0000, 32'h0000_5678, 32'hDEAD_BEEF, 4'd0, 32'h1234_5678, 4'b0000);
        op_chk("shl24",    6'h06, 1'b0, 32'h1234_0000, 32'h0000_5678, 32'h0,        4'd0, 32'h0000_0000, 4'b1000);
        op_chk("shr1",     6'h07, 1'b1, 32'h8000_0001, 32'hFFFF_FFFF, 32'h1,        4'd0, 32'h4000_0000, 4'b0010);
        op_chk("sub_neg",  6'h01, 1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0,        4'd0, 32'hFFFF_FFFF, 4'b0110);
        op_chk("add_ovf",  6'h00, 1'b1, 32'h7FFF_FFFF, 32'h0,        32'h1,        4'd0, 32'h8000_0000, 4'b0101);
        op_chk("add_cry",  6'h00, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0,        4'd0, 32'h0000_0000, 4'b1010);
        op_chk("sub_sovf", 6'h01, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h0,        4'd0, 32'h7FFF_FFFF, 4'b0001);
        op_chk("xor",      6'h04, 1'b0, 32'hF0F0_0000, 32'h0F0F_0000, 32'h0,        4'd0, 32'hFFFF_0000, 4'b0100);
        op_chk("and",      6'h02, 1'b1, 32'hF0F0_1234, 32'h0,        32'h0F0F_FFFF, 4'd0, 32'h0000_1234, 4'b0000);
        op_chk("or",       6'h03, 1'b0, 32'h0000_00F0, 32'h0000_000F, 32'h0,        4'd0, 32'h0000_00FF, 4'b0000);
        op_chk("not",      6'h05, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0,        4'd0, 32'h0000_0000, 4'b1000);
        op_chk("mov",      6'h09, 1'b1, 32'h0,        32'h0,        32'h8765_4321, 4'd0, 32'h8765_4321, 4'b0100);
        op_chk("sar4",     6'h08, 1'b0, 32'h8000_0000, 32'h0000_0004, 32'h0,        4'd0, 32'hF800_0000, 4'b0100);
        op_chk("shl_wrap", 6'h06, 1'b1, 32'h8000_0001, 32'h0,        32'h0000_0021, 4'd0, 32'h0000_0002, 4'b0010);
        op_chk("shr_zero", 6'h07, 1'b1, 32'h0000_0003, 32'h0,        32'h0000_0020, 4'd0, 32'h0000_0003, 4'b0000);

        op_chk("cmp_eq",   6'h0B, 1'b0, 32'h0000_0005, 32'h0000_0005, 32'h0,        4'd0, 32'h0000_0005, 4'b1000);
        op_chk("movcc_eq", 6'h0A, 1'b1, 32'hAAAA_AAAA, 32'h0,        32'h5555_5555, 4'd1, 32'h5555_5555, 4'b1000);
        op_chk("movcc_ne", 6'h0A, 1'b1, 32'hAAAA_AAAA, 32'h0,        32'h5555_5555, 4'd2, 32'hAAAA_AAAA, 4'b1000);
        op_chk("cmp_lt",   6'h0B, 1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0,        4'd0, 32'h0000_0001, 4'b0110);
        op_chk("movcc_ltu",6'h0A, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h0,        4'd5, 32'h2222_2222, 4'b0110);
        op_chk("movcc_ge", 6'h0A, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h0,        4'd4, 32'h1111_1111, 4'b0110);
        op_chk("movcc_lt", 6'h0A, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h0,        4'd3, 32'h2222_2222, 4'b0110);
        op_chk("movcc_geu",6'h0A, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h0,        4'd6, 32'h1111_1111, 4'b0110);
        op_chk("movcc_al", 6'h0A, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h0,        4'd0, 32'h2222_2222, 4'b0110);
        op_chk("movcc_nv", 6'h0A, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h0,        4'd7, 32'h1111_1111, 4'b0110);

        // Asynchronous reset in the middle of the high phase.
        do_op(6'h00, 1'b0, 32'h0000_1000, 32'h8000_0000, 32'h0, 4'd0);
        chk("pre_rst.data", data_o, 32'h8000_1000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.data", data_o, 32'h0);
        chk("async_rst.flags", {28'h0, flags_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        op_chk("post_rst", 6'h00, 1'b0, 32'h0000_0001, 32'h0000_0001, 32'h0, 4'd0, 32'h0000_0002, 4'b0000);

        op_chk("cmp_z",    6'h0B, 1'b0, 32'h0000_0007, 32'h0000_0007, 32'h0, 4'd0, 32'h0000_0007, 4'b1000);
        op_chk("undef3f",  6'h3F, 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h0, 4'd0, 32'h0000_0000, 4'b1000);
        op_chk("undef0c",  6'h0C, 1'b1, 32'h1234_5678, 32'h0,        32'h1, 4'd0, 32'h0000_0000, 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/execute.md
Name: execute

Overview:
- Execute stage of the Venus integer pipeline.
- Takes a decoded opcode, two register operands, an immediate and a condition-code selector, and computes a 32-bit result.
- Result is registered: one-cycle latency to the write-back stage.
- Holds the architectural flags register (Z, N, C, V), which is updated by arithmetic, logic and shift ops and read by conditional moves.

Parameters:
- LEN_OPECODE, 6: opcode width
- LEN_IMMF, 1: immediate-select flag width
- LEN_REG, 32: register/data width
- LEN_CC, 4: condition-code selector width
- LEN_IMM_EX, 32: sign-extended immediate width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- opecode  in  LEN_OPECODE  operation select
- immf  in  LEN_IMMF  1: operand B = imm_ex; 0: operand B = data_rs
- data_rd  in  LEN_REG  operand A (destination register's current value)
- data_rs  in  LEN_REG  source register value
- cc  in  LEN_CC  condition selector for MOVCC
- imm_ex  in  LEN_IMM_EX  extended immediate
- data_o  out  LEN_REG  registered result
- flags_o  out  4  registered flags {Z,N,C,V}

Behaviour:
- Reset: while rst_n=0, data_o=0 and flags=0, asynchronously; both hold until the first rising edge after release.
- Operand B: B = immf ? imm_ex : data_rs.
- An X on the unselected operand must not affect the result.
- Every rising edge: data_o <= f(opecode, A, B); flags update per op.
- Latency is exactly 1 cycle; no handshake; new op accepted every cycle.
- Opcode encodings (hex):
  - ADD 00: A+B
  - SUB 01: A-B
  - AND 02
  - OR 03
  - XOR 04
  - NOT 05: ~B
  - SHL 06: A<<B[4:0]
  - SHR 07: logical right shift, A>>B[4:0]
  - SAR 08: arithmetic right shift, A>>>B[4:0]
  - MOV 09: B
  - MOVCC 0A: cond(cc) ? B : A
  - CMP 0B: result A, flags from A-B
- Shift amount: only B[4:0] is used; upper bits are ignored.
- Arithmetic is mod 2^32.
- Flag rules:
  - ADD: C = carry-out; V = signed overflow.
  - SUB/CMP: C = borrow (1 iff A<B unsigned); V = signed overflow.
  - Logic ops, NOT and MOV: C=0, V=0.
  - Shifts: C = last bit shifted out; C=0 when amount=0; V=0.
  - Z and N are taken from the 32-bit result (from A-B for CMP).
  - MOVCC leaves all flags unchanged.
- cc decode (evaluated on the current registered flags):
  - 0 always
  - 1 EQ (Z)
  - 2 NE (!Z)
  - 3 LT (N^V)
  - 4 GE (!(N^V))
  - 5 LTU (C)
  - 6 GEU (!C)
  - 7–15 never
- Undefined opcode: data_o <= 0; flags unchanged.
- Back-to-back ops: a MOVCC sees the flags written by the immediately preceding op; there is no extra bubble.
- Reset asserted mid-stream: any in-flight result is discarded and outputs go to 0 immediately.

Decomposition:
- Shared include/package defs_insn holds:
  - LEN_* widths
  - OPECODE_* encodings
  - CC_* selector values
  - flag bit indices
- One natural sub-module: execute_alu. It is purely combinational: opcode, A, B, cc, current flags -> result, next flags.
- execute itself contains the operand mux, the registers and the reset.

Test Plan:
1. ADD, immf=0, rd=0x1234_0000, rs=0x0000_5678, imm_ex=X -> next cycle data_o=0x1234_5678, Z=0 N=0 C=0 V=0.
2. SHL, immf=0, rd=0x1234_0000, rs=0x0000_5678 (amount 24) -> data_o=0x0000_0000, Z=1, C=0. Then SHR with rd=0x8000_0001, immf=1, imm_ex=1 -> data_o=0x4000_0000, C=1.
3. SUB, rd=0x0000_0001, rs=0x0000_0002 -> data_o=0xFFFF_FFFF, N=1, C=1, Z=0. Then ADD 0x7FFF_FFFF+1 -> 0x8000_0000, V=1.
4. CMP rd=5, rs=5 (Z=1) then MOVCC cc=1, rd=0xAAAA_AAAA, imm_ex=0x5555_5555, immf=1 -> 0x5555_5555. The same MOVCC with cc=2 -> 0xAAAA_AAAA.
5. Assert rst_n=0 mid-sequence, asynchronous to clk -> data_o=0 and flags_o=0 immediately. After release, first ADD 1+1 -> 2.
6. Undefined opcode 0x3F after an op that set Z=1 -> data_o=0, flags_o still shows Z=1.
